// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared constants and types for the ALU scheduler.
// Opcode encodings, flag bit positions, default widths and the
// round-robin pointer type used by the arbiter.
package alu_sched_pkg;

  localparam int DW_DEFAULT  = 16;
  localparam int OPW_DEFAULT = 3;

  // ALU opcodes
  localparam logic [2:0] ADD    = 3'b000;
  localparam logic [2:0] PADDSB = 3'b001;
  localparam logic [2:0] SUB    = 3'b010;
  localparam logic [2:0] AND    = 3'b011;
  localparam logic [2:0] NOR    = 3'b100;
  localparam logic [2:0] SLL    = 3'b101;
  localparam logic [2:0] SRL    = 3'b110;
  localparam logic [2:0] SRA    = 3'b111;

  // Flag bit indices within {neg, ov, zr}
  localparam int NEG = 2;
  localparam int OV  = 1;
  localparam int ZR  = 0;

  // Which requester wins the next tie
  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
// One-hot grant from an eligible vector; the pointer only moves when
// both inputs compete, so a lone requester never disturbs fairness.
module rr_arb2
  import alu_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_elig,
  output logic [1:0] o_gnt
);

  rr_ptr_e r_ptr;
  rr_ptr_e w_ptr_nxt;

  // Pointer register, cleared to favour requester 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PTR_REQ0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Grant decode and next pointer; pointer flips only on a tie
  always_comb begin
    o_gnt     = 2'b00;
    w_ptr_nxt = r_ptr;
    case (i_elig)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        if (r_ptr == PTR_REQ0) begin
          o_gnt     = 2'b01;
          w_ptr_nxt = PTR_REQ1;
        end else begin
          o_gnt     = 2'b10;
          w_ptr_nxt = PTR_REQ0;
        end
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one combinational ALU between two requesters.
// Round-robin grant, same-cycle ALU drive, one-entry response buffer per
// requester and the architectural {neg, ov, zr} flag register.
// Optional macro ALU_SCHED_STALL_CNT_EN adds saturating stall counters.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int OPW = OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req0_setf,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic           req1_setf,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_result,
  output logic [2:0]     rsp0_flags,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_result,
  output logic [2:0]     rsp1_flags,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_src0,
  output logic [DW-1:0]  alu_src1,
  input  logic [DW-1:0]  alu_result,
  input  logic [2:0]     alu_flags,
`ifdef ALU_SCHED_STALL_CNT_EN
  output logic [15:0]    stall_cnt0,
  output logic [15:0]    stall_cnt1,
`endif
  output logic [2:0]     flag_reg
);

  logic          r_rsp0_valid;
  logic [DW-1:0] r_rsp0_result;
  logic [2:0]    r_rsp0_flags;
  logic          r_rsp1_valid;
  logic [DW-1:0] r_rsp1_result;
  logic [2:0]    r_rsp1_flags;
  logic [2:0]    r_flag;

  logic       w_slot_free0;
  logic       w_slot_free1;
  logic [1:0] w_elig;
  logic [1:0] w_gnt;
  logic       w_flag_we;

  // A slot is free when empty or being drained this cycle
  assign w_slot_free0 = !r_rsp0_valid || rsp0_ready;
  assign w_slot_free1 = !r_rsp1_valid || rsp1_ready;
  assign w_elig       = {req1_valid && w_slot_free1, req0_valid && w_slot_free0};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_elig (w_elig),
    .o_gnt  (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  // ALU operand mux: requester 1 only when granted, req0 otherwise
  always_comb begin
    alu_op   = req0_op;
    alu_src0 = req0_a;
    alu_src1 = req0_b;
    if (w_gnt[1]) begin
      alu_op   = req1_op;
      alu_src0 = req1_a;
      alu_src1 = req1_b;
    end else begin
      alu_op   = req0_op;
      alu_src0 = req0_a;
      alu_src1 = req0_b;
    end
  end

  // Response buffer 0: refill on grant, clear on consume, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_flags  <= 3'b000;
    end else if (w_gnt[0]) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= alu_result;
      r_rsp0_flags  <= alu_flags;
    end else if (rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  // Response buffer 1: refill on grant, clear on consume, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_flags  <= 3'b000;
    end else if (w_gnt[1]) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= alu_result;
      r_rsp1_flags  <= alu_flags;
    end else if (rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  // Only the single granted requester can write flags, so no conflict
  assign w_flag_we = (w_gnt[0] && req0_setf) || (w_gnt[1] && req1_setf);

  // Architectural flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 3'b000;
    end else if (w_flag_we) begin
      r_flag <= alu_flags;
    end
  end

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_flags  = r_rsp0_flags;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_flags  = r_rsp1_flags;
  assign flag_reg    = r_flag;

`ifdef ALU_SCHED_STALL_CNT_EN
  logic [15:0] r_stall0;
  logic [15:0] r_stall1;

  // Requester 0 stall counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall0 <= 16'h0000;
    end else if (req0_valid && !w_gnt[0] && (r_stall0 != 16'hFFFF)) begin
      r_stall0 <= r_stall0 + 16'h0001;
    end
  end

  // Requester 1 stall counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall1 <= 16'h0000;
    end else if (req1_valid && !w_gnt[1] && (r_stall1 != 16'hFFFF)) begin
      r_stall1 <= r_stall1 + 16'h0001;
    end
  end

  assign stall_cnt0 = r_stall0;
  assign stall_cnt1 = r_stall1;
`endif

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Shares the single 16-bit combinational ALU between two requesters: req0 (execute stage) and req1 (address/auxiliary unit).
- Round-robin arbitration; drives the ALU's op and operand inputs.
- Registers each requester's result and flags in a one-entry response buffer with valid/ready handshake.
- Maintains the architectural flag register {neg, ov, zr}.

Parameters:
- DW, 16, operand/result width.
- OPW, 3, ALU opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  OPW  ALU opcode.
- req0_a, req0_b  input  DW  operands src0/src1.
- req0_setf  input  1  operation updates the flag register.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_setf: same as req0, for requester 1.
- rsp0_valid  output  1  response 0 held.
- rsp0_ready  input  1  requester 0 consumes response.
- rsp0_result  output  DW  registered result.
- rsp0_flags  output  3  registered {neg, ov, zr}.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_flags: same as rsp0, for requester 1.
- alu_op  output  OPW  to ALU ALUop.
- alu_src0, alu_src1  output  DW  to ALU operands.
- alu_result  input  DW  from ALU.
- alu_flags  input  3  from ALU {neg, ov, zr}.
- flag_reg  output  3  architectural flags {neg, ov, zr}.

Behaviour:
- Reset (async, rst_n low) clears:
  - rsp0_valid, rsp1_valid, rsp*_result, rsp*_flags and flag_reg to 0.
  - Round-robin pointer to 0 (req0 preferred first).
- Reset mid-operation discards buffered responses with no drain.
- Slot free:
  - slot_free_i = !rspi_valid || rspi_ready.
  - A requester is eligible when reqi_valid && slot_free_i.
- Grant:
  - At most one grant per cycle.
  - Exactly one eligible: it wins.
  - Both eligible: the requester named by the pointer wins, then the pointer flips to the other requester.
  - Pointer unchanged when there is no grant or only one is eligible.
- reqi_ready is combinational and equals grant_i. reqi_valid must stay asserted with stable fields until ready.
- ALU drive:
  - Granted requester's op/a/b mux onto alu_* in the same cycle.
  - With no grant, alu_* carry req0's fields (don't-care, but deterministic).
- Latency: one cycle. On the clock edge after grant_i, rspi_valid=1, rspi_result=alu_result, rspi_flags=alu_flags.
- Response slot:
  - rspi_valid clears on rspi_ready with no new grant_i.
  - Consume and refill in the same cycle keeps rspi_valid=1 with the new data (full throughput, one op/cycle total).
- Flag register:
  - On the grant edge, if the granted reqi_setf=1, flag_reg <= alu_flags.
  - Otherwise flag_reg holds.
  - Only one writer per cycle, so there is no write conflict.
- Backpressure: a held, unconsumed response blocks only its own requester. The other requester continues to receive grants.
- Fields of an ungranted request are ignored.
- Response data holds stable while rspi_valid && !rspi_ready.

Optional Feature:
- Macro: ALU_SCHED_STALL_CNT_EN.
- When defined:
  - Adds outputs stall_cnt0 and stall_cnt1 (16 bits each).
  - Each counts cycles with reqi_valid && !reqi_ready and saturates at 0xFFFF.
  - Reset to 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_sched_pkg holds:
  - opcode localparams ADD=000, PADDSB=001, SUB=010, AND=011, NOR=100, SLL=101, SRL=110, SRA=111.
  - flag bit indices NEG=2, OV=1, ZR=0.
  - DW/OPW defaults.
- One natural sub-module, rr_arb2: two-input round-robin arbiter with the eligible vector in, one-hot grant out, and an internal pointer. It uses the same clk/rst_n.

Test Plan:
- Single op: req0 ADD a=0x7FFF b=0x0001 setf=1, rsp0_ready=1. Next cycle rsp0_valid=1, result=0x8000, flags=3'b110, flag_reg=3'b110.
- Contention:
  - Both valid every cycle from reset, responses always ready.
  - Grants alternate req0, req1, req0, and so on.
  - Each requester gets exactly one grant per two cycles.
- No-flag op:
  - req1 AND 0x00F0, 0x0F00 setf=0 gives rsp1_result=0x0000, rsp1_flags=3'b001.
  - flag_reg keeps its prior value 3'b110.
- Backpressure:
  - rsp0_ready=0 with rsp0_valid=1: req0_ready stays 0 and rsp0 data is stable.
  - req1 is still granted each cycle.
  - Raising rsp0_ready grants req0 the same cycle.
- Async reset mid-stream: rst_n low between edges. All rsp*_valid and flag_reg go to 0 immediately, and the first grant after release goes to req0 under contention.
- Stall counters (ALU_SCHED_STALL_CNT_EN): req0 blocked for 5 cycles by a held rsp0 gives stall_cnt0=5. Forcing 70000 blocked cycles gives stall_cnt0=0xFFFF.
